bcd_seg_scanner: RTL
====================

BCD_SEG_SCANNER -- requirements
Module: bcd_seg_scanner

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 4, giving the number of multiplexed digits (legal range 1..8).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 1000, giving the clk cycles per digit slot (legal range >= 2).
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1: 1 means seg and dig_en are driven low when lit or enabled; 0 inverts both.
REQ-004 The block SHALL have parameter HEX_EN, default 0: 1 means codes 10..15 render as glyphs A b C d E F.
REQ-005 Port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-006 Port rst_n, input, 1 bit, synchronous active-low reset.
REQ-007 Port load, input, 1 bit, request to capture bcd_in.
REQ-008 Port bcd_in, input, 4*N_DIGITS bits, digit codes; nibble k drives digit k, and digit 0 is least significant.
REQ-009 Port blank_lz, input, 1 bit, enables leading-zero blanking; sampled every cycle.
REQ-010 Port ready, output, 1 bit, high when a load will be accepted.
REQ-011 Port seg, output, 7 bits: seg[6]=a, seg[5]=b, seg[4]=c, seg[3]=d, seg[2]=e, seg[1]=f, seg[0]=g.
REQ-012 Port dig_en, output, N_DIGITS bits, per-digit common enable; dig_en[k] selects digit k.

Function
REQ-013 The load handshake SHALL fire on any cycle with load=1 and ready=1: bcd_in is copied to a shadow register, pending is set, and ready drops on the following cycle.
REQ-014 Any load asserted while ready=0 SHALL be ignored, with no stall and no queuing.
REQ-015 Counter div_cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; digit index idx SHALL advance by 1 on each wrap, going N_DIGITS-1 -> 0.
REQ-016 The frame boundary is the edge on which idx wraps N_DIGITS-1 -> 0. At that edge, if pending=1, the display register SHALL take the shadow value, pending SHALL clear, and ready SHALL be 1 on the next cycle.
REQ-017 Display content SHALL therefore change only at a frame boundary, so a frame is never torn.
REQ-018 A handshake on the same edge as a frame boundary SHALL set pending. The shadow value SHALL be applied at the next boundary, not the current one.
REQ-019 seg and dig_en SHALL be registered, reflecting the idx, div_cnt and display values of the previous cycle (1-cycle latency).
REQ-020 Exactly one dig_en bit, bit idx, SHALL be active, except in the two cases below, when all bits are inactive.
REQ-021 Ghost guard: all dig_en bits SHALL be inactive for the slot cycle where div_cnt=0.
REQ-022 Blanked digit: dig_en SHALL be all inactive and seg SHALL be all segments off.
REQ-023 Decode values are given for ACTIVE_LOW=1; ACTIVE_LOW=0 SHALL output the bitwise inverse.
- Digits 0-9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
- HEX_EN=1, codes 10-15: 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
- HEX_EN=0, codes 10-15: 0110000 ("E" error glyph).
REQ-024 With blank_lz=1, digit k>0 SHALL be blanked when digit k and every higher digit hold code 0. Digit 0 SHALL never be blanked.
REQ-025 With N_DIGITS=1, idx SHALL stay 0 and every slot wrap SHALL also count as a frame boundary.

Reset
REQ-026 While rst_n=0 at a rising edge, the next state SHALL be:
- div_cnt=0, idx=0, pending=0, ready=1;
- shadow and display registers = all zero;
- seg = all segments off;
- dig_en = all inactive.
REQ-027 On the first cycle after release, the display SHALL show digit 0 with code 0. Its dig_en is held inactive for that cycle by the ghost guard (REQ-021).
REQ-028 Reset asserted mid-frame or with pending=1 SHALL discard the pending data, with no partial update reaching the display.

Verification
REQ-029 N_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1: load bcd_in=16'h1234 after reset -> ready low until the first frame boundary, then the scan shows:
- digit 0: seg=1001100, dig_en=1110;
- digit 1: seg=0000110, dig_en=1101;
- digit 2: seg=0010010, dig_en=1011;
- digit 3: seg=1001111, dig_en=0111;
- dig_en=1111 on every div_cnt=0 cycle.
REQ-030 blank_lz=1, bcd_in=16'h0005 -> digits 3..1 show seg=1111111 with dig_en=1111 in their slots; digit 0 shows 0100100. Same with blank_lz=0 -> digits 3..1 show 0000001.
REQ-031 HEX_EN=0, bcd_in nibble=4'hB -> seg=0110000. HEX_EN=1 -> seg=1100000. ACTIVE_LOW=0 with digit 8 -> seg=1111111.
REQ-032 Load on the exact frame-boundary edge, then load=1 held high -> display unchanged that frame; one capture only; new value applied at the following boundary; all loads while ready=0 ignored.
REQ-033 rst_n=0 for 1 cycle mid-slot with pending=1 -> next cycle ready=1, dig_en=1111, seg=1111111. Display returns to all-zero digits, and the old shadow value never appears.

Source files
------------

// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: multiplexed 7-segment driver for N_DIGITS BCD/hex digits.
// A one-deep shadow register takes new codes via a load/ready handshake and
// hands them to the display register only at a frame boundary, so a scan
// frame always shows one consistent value.

// Per-digit leading-zero lane: a digit is a leading zero when it and every
// higher digit hold code 0.
module bcd_seg_lane (
    input  logic [3:0] code,
    input  logic       higher_zero,
    input  logic       blank_lz,
    output logic       zero_up,
    output logic       blank
);
    assign zero_up = (code == 4'd0) && higher_zero;
    assign blank   = blank_lz && zero_up;
endmodule

module bcd_seg_scanner #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int ACTIVE_LOW  = 1,
    parameter int HEX_EN      = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   bcd_in,
    input  logic                    blank_lz,
    output logic                    ready,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     dig_en
);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [DW-1:0]                div_cnt;
    logic [IW-1:0]                idx;
    logic                         pending;
    logic                         pending_nxt;
    logic [N_DIGITS-1:0][3:0]     shadow;
    logic [N_DIGITS-1:0][3:0]     display;

    logic                         slot_wrap;
    logic                         frame_wrap;
    logic                         fire;

    logic [N_DIGITS:1]            hz;
    logic [N_DIGITS-1:0]          blanked;

    logic [3:0]                   cur_code;
    logic                         cur_blank;
    logic [N_DIGITS-1:0]          onehot;
    logic [6:0]                   seg_al;
    logic [N_DIGITS-1:0]          en_al;

    // Active-low glyph table; codes 10..15 show hex letters or an error "E".
    function automatic logic [6:0] decode(input logic [3:0] c);
        logic [6:0] g;
        case (c)
            4'd0:    g = 7'b0000001;
            4'd1:    g = 7'b1001111;
            4'd2:    g = 7'b0010010;
            4'd3:    g = 7'b0000110;
            4'd4:    g = 7'b1001100;
            4'd5:    g = 7'b0100100;
            4'd6:    g = 7'b0100000;
            4'd7:    g = 7'b0001111;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0000100;
            4'd10:   g = (HEX_EN != 0) ? 7'b0001000 : 7'b0110000;
            4'd11:   g = (HEX_EN != 0) ? 7'b1100000 : 7'b0110000;
            4'd12:   g = (HEX_EN != 0) ? 7'b0110001 : 7'b0110000;
            4'd13:   g = (HEX_EN != 0) ? 7'b1000010 : 7'b0110000;
            4'd14:   g = 7'b0110000;
            default: g = (HEX_EN != 0) ? 7'b0111000 : 7'b0110000;
        endcase
        return g;
    endfunction

    assign slot_wrap  = (div_cnt == DW'(REFRESH_DIV - 1));
    assign frame_wrap = slot_wrap && (idx == IW'(N_DIGITS - 1));
    assign fire       = load && ready;

    // Leading-zero chain runs from the top digit down; digit 0 is never blanked.
    assign hz[N_DIGITS] = 1'b1;
    assign blanked[0]   = 1'b0;
    generate
        for (genvar k = 1; k < N_DIGITS; k++) begin : g_lane
            bcd_seg_lane u_lane (
                .code        (display[k]),
                .higher_zero (hz[k+1]),
                .blank_lz    (blank_lz),
                .zero_up     (hz[k]),
                .blank       (blanked[k])
            );
        end
    endgenerate

    // Pending flag: a boundary consumes the shadow, a handshake refills it.
    // Both cannot coincide because a handshake needs pending clear.
    always_comb begin
        pending_nxt = pending;
        if (frame_wrap && pending)
            pending_nxt = 1'b0;
        if (fire)
            pending_nxt = 1'b1;
    end

    // Scan counters, handshake and frame-synchronous display update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
            pending <= 1'b0;
            ready   <= 1'b1;
            shadow  <= '0;
            display <= '0;
        end else begin
            div_cnt <= slot_wrap ? '0 : div_cnt + 1'b1;
            if (slot_wrap)
                idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
            if (frame_wrap && pending)
                display <= shadow;
            if (fire)
                shadow <= bcd_in;
            pending <= pending_nxt;
            ready   <= ~pending_nxt;
        end
    end

    // Select the code, blank flag and enable bit of the digit being scanned.
    always_comb begin
        cur_code  = '0;
        cur_blank = 1'b0;
        onehot    = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_code  = display[k];
                cur_blank = blanked[k];
                onehot[k] = 1'b1;
            end
        end
    end

    // Active-low view; blanked digits and the first slot cycle stay dark.
    always_comb begin
        seg_al = cur_blank ? 7'h7F : decode(cur_code);
        en_al  = (cur_blank || div_cnt == '0) ? '1 : ~onehot;
    end

    // Registered drivers with output polarity applied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg    <= (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
            dig_en <= (ACTIVE_LOW != 0) ? '1 : '0;
        end else begin
            seg    <= (ACTIVE_LOW != 0) ? seg_al : ~seg_al;
            dig_en <= (ACTIVE_LOW != 0) ? en_al : ~en_al;
        end
    end
endmodule
